mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS core.
- Sequences the shared datapath through fetch, decode, execute, memory and writeback: PC, IM/IR, RF, EXT, ALU, DM, NPC and the write-back muxes.
- Decodes the latched instruction's op/funct and drives every write enable and mux select, so one ALU and one register-file port set are time-shared across instruction phases.
- Replaces the combinational single-cycle controller in the multi-cycle top.

---
 rtl/mc_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control FSM for the MIPS core.
//
// Walks the shared datapath through FETCH, DCD, EXE, MEM, WB and BR.
// Every output is decoded from the state register plus the op/funct of the
// latched instruction. The ALU and the register-file ports are therefore
// time-shared across the phases of one instruction.
//
// Parameters
//   RA_IDX  register index written by jal. The datapath applies it when
//           ra_sel = 2; the controller only selects that source.
//   ST_W    width of the state encoding (3 or more).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   op, funct    IR[31:26] and IR[5:0]
//   zero         ALU zero flag, used in BR
//   dm_ready     data-memory ready (only honoured with MC_DMRDY_EN)
//   pc_wr        PC load enable
//   ir_wr        IR load enable
//   rf_wr        register-file write enable
//   dm_wr        data-memory write enable
//   npc_op       next-PC source (0 PC+4, 1 branch, 2 jump, 3 jr)
//   alu_op       0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI
//   alu_srcb     ALU B source (0 rt, 1 extended immediate)
//   alu_srca_sh  shift form: A = rt, B = shamt
//   ext_op       0 zero-extend, 1 sign-extend, 2 upper (lui)
//   ra_sel       destination register (0 rt, 1 rd, 2 RA_IDX)
//   wd_sel       write-back data (0 ALU, 1 DM, 2 PC+4)
//   state        current state, for debug
//   instr_done   pulse on the final cycle of an instruction
//   illegal      pulse when decode finds an unsupported op/funct
//
// Build option
//   MC_DMRDY_EN  when defined, MEM waits for dm_ready. When undefined,
//                dm_ready is ignored and MEM always lasts one cycle.
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int RA_IDX = 31,
    parameter int ST_W   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            dm_ready,
    output logic            pc_wr,
    output logic            ir_wr,
    output logic            rf_wr,
    output logic            dm_wr,
    output logic [1:0]      npc_op,
    output logic [3:0]      alu_op,
    output logic            alu_srcb,
    output logic            alu_srca_sh,
    output logic [1:0]      ext_op,
    output logic [1:0]      ra_sel,
    output logic [1:0]      wd_sel,
    output logic [ST_W-1:0] state,
    output logic            instr_done,
    output logic            illegal
);

    typedef enum logic [ST_W-1:0] {
        S_RST   = ST_W'(0),
        S_FETCH = ST_W'(1),
        S_DCD   = ST_W'(2),
        S_EXE   = ST_W'(3),
        S_MEM   = ST_W'(4),
        S_WB    = ST_W'(5),
        S_BR    = ST_W'(6)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    state_t state_reg;
    state_t state_next;

    // Instruction-class decode of the latched IR fields.
    logic is_rtype;
    logic is_alu_r;
    logic is_jr;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_imm_alu;
    logic is_j;
    logic is_jal;

    assign is_rtype   = (op == OP_RTYPE);
    assign is_jr      = is_rtype && (funct == FN_JR);
    assign is_alu_r   = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU) ||
                                     (funct == FN_AND)  || (funct == FN_OR)   ||
                                     (funct == FN_SLT)  || (funct == FN_SLL)  ||
                                     (funct == FN_SRL));
    assign is_lw      = (op == OP_LW);
    assign is_sw      = (op == OP_SW);
    assign is_beq     = (op == OP_BEQ);
    assign is_bne     = (op == OP_BNE);
    assign is_imm_alu = (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LUI);
    assign is_j       = (op == OP_J);
    assign is_jal     = (op == OP_JAL);

    // ALU selects set up in EXE. They are reused unchanged in MEM and WB so
    // the ALU result (address or write-back value) stays stable.
    logic [3:0] exe_alu_op;
    logic       exe_srcb;
    logic       exe_sh;
    logic [1:0] exe_ext;

    always_comb begin
        exe_alu_op = ALU_ADD;
        exe_srcb   = 1'b0;
        exe_sh     = 1'b0;
        exe_ext    = 2'd0;
        if (is_rtype) begin
            case (funct)
                FN_SUBU: exe_alu_op = ALU_SUB;
                FN_AND:  exe_alu_op = ALU_AND;
                FN_OR:   exe_alu_op = ALU_OR;
                FN_SLT:  exe_alu_op = ALU_SLT;
                FN_SLL:  begin exe_alu_op = ALU_SLL; exe_sh = 1'b1; end
                FN_SRL:  begin exe_alu_op = ALU_SRL; exe_sh = 1'b1; end
                default: exe_alu_op = ALU_ADD;
            endcase
        end else if (op == OP_ORI) begin
            exe_srcb   = 1'b1;
            exe_ext    = 2'd0;
            exe_alu_op = ALU_OR;
        end else if (op == OP_LUI) begin
            exe_srcb   = 1'b1;
            exe_ext    = 2'd2;
            exe_alu_op = ALU_LUI;
        end else begin
            // addi, lw, sw: base + sign-extended immediate
            exe_srcb   = 1'b1;
            exe_ext    = 2'd1;
            exe_alu_op = ALU_ADD;
        end
    end

    // The async reset forces RST, whose decode drives every enable low, so
    // pending writes drop as soon as rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        rf_wr       = 1'b0;
        dm_wr       = 1'b0;
        npc_op      = 2'd0;
        alu_op      = ALU_ADD;
        alu_srcb    = 1'b0;
        alu_srca_sh = 1'b0;
        ext_op      = 2'd0;
        ra_sel      = 2'd0;
        wd_sel      = 2'd0;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        case (state_reg)
            S_RST: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                pc_wr      = 1'b1;
                ir_wr      = 1'b1;
                npc_op     = 2'd0;
                state_next = S_DCD;
            end

            S_DCD: begin
                if (is_j || is_jal) begin
                    pc_wr      = 1'b1;
                    npc_op     = 2'd2;
                    instr_done = 1'b1;
                    // PC already holds PC+4 of this jal, so it is the link value.
                    if (is_jal) begin
                        rf_wr  = 1'b1;
                        ra_sel = 2'd2;
                        wd_sel = 2'd2;
                    end
                    state_next = S_FETCH;
                end else if (is_jr) begin
                    pc_wr      = 1'b1;
                    npc_op     = 2'd3;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (is_beq || is_bne) begin
                    state_next = S_BR;
                end else if (is_alu_r || is_imm_alu || is_lw || is_sw) begin
                    state_next = S_EXE;
                end else begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
            end

            S_EXE: begin
                alu_op      = exe_alu_op;
                alu_srcb    = exe_srcb;
                alu_srca_sh = exe_sh;
                ext_op      = exe_ext;
                state_next  = (is_lw || is_sw) ? S_MEM : S_WB;
            end

            S_MEM: begin
                alu_op      = exe_alu_op;
                alu_srcb    = exe_srcb;
                alu_srca_sh = exe_sh;
                ext_op      = exe_ext;
                dm_wr       = is_sw;
`ifdef MC_DMRDY_EN
                // Hold every output, including dm_wr, until memory accepts.
                if (dm_ready) begin
                    instr_done = is_sw;
                    state_next = is_sw ? S_FETCH : S_WB;
                end
`else
                instr_done = is_sw;
                state_next = is_sw ? S_FETCH : S_WB;
`endif
            end

            S_WB: begin
                alu_op      = exe_alu_op;
                alu_srcb    = exe_srcb;
                alu_srca_sh = exe_sh;
                ext_op      = exe_ext;
                rf_wr       = 1'b1;
                instr_done  = 1'b1;
                ra_sel      = is_rtype ? 2'd1 : 2'd0;
                wd_sel      = is_lw ? 2'd1 : 2'd0;
                state_next  = S_FETCH;
            end

            S_BR: begin
                alu_op     = ALU_SUB;
                alu_srcb   = 1'b0;
                ext_op     = 2'd1;
                npc_op     = 2'd1;
                pc_wr      = is_beq ? zero : ~zero;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

            default: begin
                state_next = S_RST;
            end
        endcase
    end

    assign state = state_reg;

    // RA_IDX is consumed by the datapath. dm_ready has no effect when the
    // stall option is compiled out.
    logic unused_ok;
`ifdef MC_DMRDY_EN
    assign unused_ok = (RA_IDX != 0);
`else
    assign unused_ok = ^{dm_ready, (RA_IDX != 0)};
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
// Each instruction pushes its expected per-cycle output vectors to a queue.
// One vector is popped and compared per clock.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       dm_ready;
    logic       pc_wr;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic [1:0] npc_op;
    logic [3:0] alu_op;
    logic       alu_srcb;
    logic       alu_srca_sh;
    logic [1:0] ext_op;
    logic [1:0] ra_sel;
    logic [1:0] wd_sel;
    logic [2:0] state;
    logic       instr_done;
    logic       illegal;

    mc_ctrl #(.RA_IDX(31), .ST_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .dm_ready    (dm_ready),
        .pc_wr       (pc_wr),
        .ir_wr       (ir_wr),
        .rf_wr       (rf_wr),
        .dm_wr       (dm_wr),
        .npc_op      (npc_op),
        .alu_op      (alu_op),
        .alu_srcb    (alu_srcb),
        .alu_srca_sh (alu_srca_sh),
        .ext_op      (ext_op),
        .ra_sel      (ra_sel),
        .wd_sel      (wd_sel),
        .state       (state),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector:
    // {state, pc_wr, ir_wr, rf_wr, dm_wr, npc_op, alu_op, srcb, sh, ext, ra, wd, done, ill}
    logic [22:0] obs;
    assign obs = {state, pc_wr, ir_wr, rf_wr, dm_wr, npc_op, alu_op, alu_srcb,
                  alu_srca_sh, ext_op, ra_sel, wd_sel, instr_done, illegal};

    typedef struct {
        logic [22:0] vec;
        logic        dmr;
        string       tag;
    } rec_t;

    rec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        else
            n_pass++;
    endtask

    function automatic logic [22:0] mkv(input int st, input int pc, input int ir,
                                        input int rf, input int dm, input int npc,
                                        input int alu, input int srcb, input int sh,
                                        input int ext, input int ra, input int wd,
                                        input int done, input int ill);
        return {3'(st), 1'(pc), 1'(ir), 1'(rf), 1'(dm), 2'(npc), 4'(alu), 1'(srcb),
                1'(sh), 2'(ext), 2'(ra), 2'(wd), 1'(done), 1'(ill)};
    endfunction

    task automatic push(input string tag, input logic [22:0] v, input logic dmr);
        rec_t r;
        r.vec = v;
        r.dmr = dmr;
        r.tag = tag;
        sb.push_back(r);
    endtask

    // Reference model: the expected cycle-by-cycle behaviour of one instruction.
    task automatic push_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input int stall);
        int alu, srcb, sh, ext, ra, wd;
        bit alu_class, mem_class, is_sw;
        alu = 0; srcb = 0; sh = 0; ext = 0; ra = 0; wd = 0;
        alu_class = 0; mem_class = 0; is_sw = 0;
        push({nm, ".fetch"}, mkv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        case (o)
            6'b000010: push({nm, ".dcd"}, mkv(2, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
            6'b000011: push({nm, ".dcd"}, mkv(2, 1, 0, 1, 0, 2, 0, 0, 0, 0, 2, 2, 1, 0), 1'b1);
            6'b000100, 6'b000101: begin
                push({nm, ".dcd"}, mkv(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
                push({nm, ".br"}, mkv(6, (o == 6'b000100) ? int'(z) : int'(!z), 0, 0, 0, 1,
                                      1, 0, 0, 1, 0, 0, 1, 0), 1'b1);
            end
            6'b000000: begin
                alu_class = 1; ra = 1;
                case (f)
                    6'b100001: alu = 0;
                    6'b100011: alu = 1;
                    6'b100100: alu = 2;
                    6'b100101: alu = 3;
                    6'b101010: alu = 4;
                    6'b000000: begin alu = 5; sh = 1; end
                    6'b000010: begin alu = 6; sh = 1; end
                    6'b001000: begin
                        alu_class = 0;
                        push({nm, ".dcd"}, mkv(2, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
                    end
                    default: begin
                        alu_class = 0;
                        push({nm, ".dcd"}, mkv(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b1);
                    end
                endcase
            end
            6'b001000: begin alu_class = 1; srcb = 1; ext = 1; end
            6'b001101: begin alu_class = 1; srcb = 1; ext = 0; alu = 3; end
            6'b001111: begin alu_class = 1; srcb = 1; ext = 2; alu = 7; end
            6'b100011: begin alu_class = 1; mem_class = 1; srcb = 1; ext = 1; wd = 1; end
            6'b101011: begin alu_class = 1; mem_class = 1; is_sw = 1; srcb = 1; ext = 1; end
            default: push({nm, ".dcd"}, mkv(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b1);
        endcase
        if (alu_class) begin
            push({nm, ".dcd"}, mkv(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
            push({nm, ".exe"}, mkv(3, 0, 0, 0, 0, 0, alu, srcb, sh, ext, 0, 0, 0, 0), 1'b1);
            if (mem_class) begin
`ifdef MC_DMRDY_EN
                for (int i = 0; i < stall; i++)
                    push({nm, ".mem_wait"}, mkv(4, 0, 0, 0, int'(is_sw), 0, alu, srcb, sh, ext,
                                                0, 0, 0, 0), 1'b0);
                push({nm, ".mem"}, mkv(4, 0, 0, 0, int'(is_sw), 0, alu, srcb, sh, ext,
                                       0, 0, int'(is_sw), 0), 1'b1);
`else
                // dm_ready is ignored: MEM always takes one cycle.
                push({nm, ".mem"}, mkv(4, 0, 0, 0, int'(is_sw), 0, alu, srcb, sh, ext,
                                       0, 0, int'(is_sw), 0), (stall > 0) ? 1'b0 : 1'b1);
`endif
            end
            if (!is_sw)
                push({nm, ".wb"}, mkv(5, 0, 0, 1, 0, 0, alu, srcb, sh, ext, ra, wd, 1, 0), 1'b1);
        end
    endtask

    // Pop up to n expected vectors, one per cycle. Entered at a negedge.
    task automatic drain(input int n);
        rec_t r;
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            r = sb.pop_front();
            dm_ready = r.dmr;
            #1;
            check(r.tag, 32'(obs), 32'(r.vec));
            $display("cycle %-14s state=%0d obs=%h", r.tag, state, obs);
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int stall);
        op = o;
        funct = f;
        zero = z;
        push_instr(nm, o, f, z, stall);
        drain(sb.size());
    endtask

    initial begin
        rst = 1'b0;
        op = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        dm_ready = 1'b1;

        // Reset held for three cycles: RST state with all outputs low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 32'(obs), 32'(0));
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_rst_cycle", 32'(obs), 32'(0));
        @(negedge clk);

        run_instr("addu", 6'b000000, 6'b100001, 1'b0, 0);
        run_instr("subu", 6'b000000, 6'b100011, 1'b0, 0);
        run_instr("and",  6'b000000, 6'b100100, 1'b0, 0);
        run_instr("or",   6'b000000, 6'b100101, 1'b0, 0);
        run_instr("slt",  6'b000000, 6'b101010, 1'b0, 0);
        run_instr("sll",  6'b000000, 6'b000000, 1'b0, 0);
        run_instr("srl",  6'b000000, 6'b000010, 1'b0, 0);
        run_instr("addi", 6'b001000, 6'b010101, 1'b0, 0);
        run_instr("ori",  6'b001101, 6'b000000, 1'b0, 0);
        run_instr("lui",  6'b001111, 6'b111111, 1'b0, 0);
        run_instr("lw",   6'b100011, 6'b000000, 1'b0, 0);
        run_instr("sw",   6'b101011, 6'b000000, 1'b0, 0);
        run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, 0);
        run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, 0);
        run_instr("bne_z1", 6'b000101, 6'b000000, 1'b1, 0);
        run_instr("bne_z0", 6'b000101, 6'b000000, 1'b0, 0);
        run_instr("j",    6'b000010, 6'b000000, 1'b0, 0);
        run_instr("jal",  6'b000011, 6'b000000, 1'b0, 0);
        run_instr("jr",   6'b000000, 6'b001000, 1'b0, 0);
        run_instr("ill_op", 6'b111111, 6'b000000, 1'b0, 0);
        run_instr("ill_fn", 6'b000000, 6'b111111, 1'b0, 0);
        run_instr("lw_stall", 6'b100011, 6'b000000, 1'b0, 2);
        run_instr("sw_stall", 6'b101011, 6'b000000, 1'b0, 2);

        // Reset during EXE of an addi: state and enables drop at once.
        op = 6'b001000;
        funct = 6'b000000;
        push_instr("addi_rst", 6'b001000, 6'b000000, 1'b0, 0);
        drain(2);
        begin
            rec_t r;
            r = sb.pop_front();
            #1;
            check(r.tag, 32'(obs), 32'(r.vec));
            sb.delete();
        end
        #2 rst = 1'b0;
        #1;
        check("rst_async", 32'(obs), 32'(0));
        $display("async reset: state=%0d obs=%h", state, obs);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mid_hold", 32'(obs), 32'(0));
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rst_cycle", 32'(obs), 32'(0));
        @(negedge clk);
        run_instr("addu_after", 6'b000000, 6'b100001, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
